// File: rtl/mic_sequencer_pkg.sv
// Shared definitions for the MIC microprogram sequencer: the microinstruction
// field layout, the ALU function encoding and the sequencer state type.
package mic_sequencer_pkg;

  localparam int MIC_ADDR_W = 9;
  localparam int MIC_MIR_W  = 36;
  localparam int MIC_MBR_W  = 8;

  // Bit positions of each microinstruction field inside the 36-bit MIR
  localparam int NEXT_ADDR_HI = 35;
  localparam int NEXT_ADDR_LO = 27;
  localparam int JAM_JMPC     = 26;
  localparam int JAM_JMPN     = 25;
  localparam int JAM_JMPZ     = 24;
  localparam int ALUF_HI      = 23;
  localparam int ALUF_LO      = 22;
  localparam int ALUMOD_HI    = 21;
  localparam int ALUMOD_LO    = 18;
  localparam int CEN_HI       = 17;
  localparam int CEN_LO       = 9;
  localparam int MEMOP_HI     = 8;
  localparam int MEMOP_LO     = 6;
  localparam int BSEL_HI      = 5;
  localparam int BSEL_LO      = 2;
  localparam int HALT_BIT     = 1;
  localparam int RSVD_BIT     = 0;

  typedef enum logic [1:0] {ALU_ADD, ALU_OR, ALU_NOTB, ALU_SUM} alu_f_t;

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_HALT} seq_state_t;

  // Field order mirrors the bit positions above, MSB first
  typedef struct packed {
    logic [8:0] next_addr;
    logic       jmpc;
    logic       jmpn;
    logic       jmpz;
    alu_f_t     alu_f;
    logic [3:0] alu_mod;
    logic [8:0] c_en;
    logic [2:0] mem_op;
    logic [3:0] b_sel;
    logic       halt;
    logic       reserved;
  } mir_t;

endpackage

// File: rtl/mic_next_addr.sv
// Next-MPC computation: ORs the N/Z jump conditions into the high address bit
// and, for a multiway branch, ORs the MBR into the low eight bits.
module mic_next_addr
  import mic_sequencer_pkg::*;
(
  input  logic [MIC_ADDR_W-1:0] next_addr_i,
  input  logic                  jmpc_i,
  input  logic                  jmpn_i,
  input  logic                  jmpz_i,
  input  logic                  alu_n_i,
  input  logic                  alu_z_i,
  input  logic [MIC_MBR_W-1:0]  mbr_i,
  output logic [MIC_ADDR_W-1:0] next_mpc_o
);

  logic                 hi;
  logic [MIC_MBR_W-1:0] lo;

  // Combine the static next address with the jam conditions
  always_comb begin
    hi = next_addr_i[MIC_ADDR_W-1] | (jmpn_i & alu_n_i) | (jmpz_i & alu_z_i);
    lo = jmpc_i ? (next_addr_i[MIC_MBR_W-1:0] | mbr_i) : next_addr_i[MIC_MBR_W-1:0];
    next_mpc_o = {hi, lo};
  end

endmodule

// File: rtl/mic_sequencer.sv
// MIC microprogram control unit: fetches a microinstruction into the MIR,
// drives its control fields for one (possibly stalled) execute phase, then
// moves to the next MPC. A HALT microinstruction parks the sequencer until reset.
module mic_sequencer
  import mic_sequencer_pkg::*;
#(
  parameter int ADDR_W = MIC_ADDR_W,
  parameter int MIR_W  = MIC_MIR_W,
  parameter int MBR_W  = MIC_MBR_W
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] cs_addr,
  input  logic [MIR_W-1:0]  cs_data,
  input  logic              alu_n,
  input  logic              alu_z,
  input  logic [MBR_W-1:0]  mbr,
  input  logic              mem_wait,
  output logic [1:0]        alu_f,
  output logic [3:0]        alu_mod,
  output logic [3:0]        b_sel,
  output logic [8:0]        c_en,
  output logic [2:0]        mem_op,
  output logic              halted
);

  seq_state_t        state_q, state_d;
  logic [ADDR_W-1:0] mpc_q, mpc_d;
  mir_t              mir_q, mir_d;
  logic              halted_q, halted_d;
  logic [ADDR_W-1:0] next_mpc;
  logic              unused_reserved;

  // The reserved microinstruction bit carries no meaning for the sequencer
  assign unused_reserved = mir_q.reserved;

  mic_next_addr u_next_addr (
    .next_addr_i (mir_q.next_addr),
    .jmpc_i      (mir_q.jmpc),
    .jmpn_i      (mir_q.jmpn),
    .jmpz_i      (mir_q.jmpz),
    .alu_n_i     (alu_n),
    .alu_z_i     (alu_z),
    .mbr_i       (mbr),
    .next_mpc_o  (next_mpc)
  );

  assign cs_addr = mpc_q;
  assign halted  = halted_q;

  // Sequencer registers; reset wins over a stall or a halt in progress
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_FETCH;
      mpc_q    <= '0;
      mir_q    <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      mpc_q    <= mpc_d;
      mir_q    <= mir_d;
      halted_q <= halted_d;
    end
  end

  // Next-state logic and control outputs, which are quiet outside EXEC
  always_comb begin
    state_d  = state_q;
    mpc_d    = mpc_q;
    mir_d    = mir_q;
    halted_d = halted_q;
    alu_f    = 2'b00;
    alu_mod  = 4'b0000;
    b_sel    = 4'b0000;
    c_en     = 9'b0;
    mem_op   = 3'b000;
    case (state_q)
      S_FETCH: begin
        mir_d   = mir_t'(cs_data);
        state_d = S_EXEC;
      end
      S_EXEC: begin
        alu_f   = mir_q.alu_f;
        alu_mod = mir_q.alu_mod;
        b_sel   = mir_q.b_sel;
        c_en    = mir_q.c_en;
        mem_op  = mir_q.mem_op;
        if (!mem_wait) begin
          if (mir_q.halt) begin
            state_d  = S_HALT;
            halted_d = 1'b1;
          end else begin
            mpc_d   = next_mpc;
            state_d = S_FETCH;
          end
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

endmodule

// File: tb/tb_mic_sequencer.sv
// Self-checking bench for mic_sequencer: a behavioural control store feeds a
// microprogram that walks through plain sequencing, conditional and multiway
// branches, a memory stall, a halt, and resets taken in HALT and mid-stall.
module tb_mic_sequencer;

  logic        clk;
  logic        rst;
  logic [8:0]  cs_addr;
  logic [35:0] cs_data;
  logic        alu_n;
  logic        alu_z;
  logic [7:0]  mbr;
  logic        mem_wait;
  logic [1:0]  alu_f;
  logic [3:0]  alu_mod;
  logic [3:0]  b_sel;
  logic [8:0]  c_en;
  logic [2:0]  mem_op;
  logic        halted;

  logic [35:0] csMem [0:511];

  typedef struct {
    string       tag;
    logic [31:0] expected;
  } sbItem_t;

  sbItem_t expQ [$];
  int checkCount = 0;
  int failCount  = 0;

  mic_sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .cs_addr  (cs_addr),
    .cs_data  (cs_data),
    .alu_n    (alu_n),
    .alu_z    (alu_z),
    .mbr      (mbr),
    .mem_wait (mem_wait),
    .alu_f    (alu_f),
    .alu_mod  (alu_mod),
    .b_sel    (b_sel),
    .c_en     (c_en),
    .mem_op   (mem_op),
    .halted   (halted)
  );

  // Control store answers in the same cycle as the address
  assign cs_data = csMem[cs_addr];

  // Free-running clock, 10 time units per cycle
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Builds one microinstruction word from its fields
  function automatic logic [35:0] mkWord(input logic [8:0] na, input logic jmpc, input logic jmpn,
                                         input logic jmpz, input logic [1:0] f, input logic [3:0] md,
                                         input logic [8:0] cen, input logic [2:0] mop,
                                         input logic [3:0] bs, input logic hlt, input logic rsv);
    return {na, jmpc, jmpn, jmpz, f, md, cen, mop, bs, hlt, rsv};
  endfunction

  // Expected observable bundle {cs_addr, alu_f, alu_mod, b_sel, c_en, mem_op, halted}
  function automatic logic [31:0] expOut(input logic [8:0] addr, input bit execPhase, input bit hlt);
    logic [35:0] w;
    w = csMem[addr];
    if (execPhase)
      return {addr, w[23:22], w[21:18], w[5:2], w[17:9], w[8:6], hlt};
    else
      return {addr, 2'b00, 4'b0000, 4'b0000, 9'b0, 3'b000, hlt};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Drives one cycle of inputs, queues the expected outputs, then compares
  // the DUT against the oldest queued expectation and advances one cycle.
  task automatic applyStimulus(input string tag, input bit rstV, input bit mw, input bit n,
                               input bit z, input logic [7:0] mbrV, input logic [8:0] expAddr,
                               input bit execPhase, input bit expHalt);
    sbItem_t item;
    sbItem_t got;
    rst      = rstV;
    mem_wait = mw;
    alu_n    = n;
    alu_z    = z;
    mbr      = mbrV;
    item.tag      = tag;
    item.expected = expOut(expAddr, execPhase, expHalt);
    expQ.push_back(item);
    #1;
    got = expQ.pop_front();
    checkOutput(got.tag, {cs_addr, alu_f, alu_mod, b_sel, c_en, mem_op, halted}, got.expected);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) csMem[i] = '0;
    csMem[9'h000] = mkWord(9'h005, 0, 0, 0, 2'd1, 4'b1100, 9'h004, 3'b000, 4'h3, 0, 0);
    csMem[9'h005] = mkWord(9'h010, 0, 0, 1, 2'd2, 4'b0110, 9'h008, 3'b000, 4'h1, 0, 0);
    csMem[9'h110] = mkWord(9'h010, 0, 0, 1, 2'd0, 4'b1101, 9'h010, 3'b001, 4'h2, 0, 0);
    csMem[9'h010] = mkWord(9'h020, 0, 1, 0, 2'd3, 4'b1111, 9'h100, 3'b000, 4'h4, 0, 0);
    csMem[9'h120] = mkWord(9'h100, 1, 0, 0, 2'd1, 4'b0010, 9'h020, 3'b100, 4'h5, 0, 1);
    csMem[9'h13C] = mkWord(9'h1FF, 1, 0, 0, 2'd2, 4'b1000, 9'h040, 3'b000, 4'h6, 0, 0);
    csMem[9'h1FF] = mkWord(9'h040, 0, 1, 0, 2'd0, 4'b1100, 9'h080, 3'b010, 4'h7, 0, 0);
    csMem[9'h040] = mkWord(9'h0AA, 0, 1, 1, 2'd3, 4'b0101, 9'h1FF, 3'b001, 4'h8, 0, 0);
    csMem[9'h1AA] = mkWord(9'h055, 0, 0, 0, 2'd0, 4'b1001, 9'h001, 3'b000, 4'h9, 1, 0);

    rst = 1'b1; mem_wait = 1'b0; alu_n = 1'b0; alu_z = 1'b0; mbr = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    $display("[TB] reset and straight-line run");
    applyStimulus("resetState", 0, 0, 0, 0, 8'h00, 9'h000, 0, 0);
    #1 checkOutput("aluF_or", {30'b0, alu_f}, 32'd1);
    applyStimulus("exec000",    0, 0, 0, 0, 8'h00, 9'h000, 1, 0);

    $display("[TB] conditional branches");
    applyStimulus("fetch005",   0, 0, 0, 0, 8'h00, 9'h005, 0, 0);
    applyStimulus("exec005",    0, 0, 0, 1, 8'hFF, 9'h005, 1, 0);
    applyStimulus("fetch110",   0, 0, 0, 0, 8'h00, 9'h110, 0, 0);
    applyStimulus("exec110",    0, 0, 1, 0, 8'h00, 9'h110, 1, 0);
    applyStimulus("fetch010",   0, 0, 0, 0, 8'h00, 9'h010, 0, 0);
    applyStimulus("exec010",    0, 0, 1, 0, 8'h00, 9'h010, 1, 0);

    $display("[TB] multiway branches");
    applyStimulus("fetch120",   0, 0, 0, 0, 8'h00, 9'h120, 0, 0);
    applyStimulus("exec120",    0, 0, 0, 0, 8'h3C, 9'h120, 1, 0);
    applyStimulus("fetch13C",   0, 0, 0, 0, 8'h00, 9'h13C, 0, 0);
    applyStimulus("exec13C",    0, 0, 0, 0, 8'hFF, 9'h13C, 1, 0);

    $display("[TB] memory stall");
    applyStimulus("fetch1FF",   0, 0, 0, 0, 8'h00, 9'h1FF, 0, 0);
    for (int i = 0; i < 3; i++) begin
      #1 checkOutput($sformatf("stallMemOp%0d", i), {29'b0, mem_op}, {29'b0, 3'b010});
      applyStimulus($sformatf("stall1FF_%0d", i), 0, 1, 1, 0, 8'h00, 9'h1FF, 1, 0);
    end
    applyStimulus("exit1FF",    0, 0, 0, 0, 8'h00, 9'h1FF, 1, 0);

    $display("[TB] both conditions and halt");
    applyStimulus("fetch040",   0, 0, 0, 0, 8'h00, 9'h040, 0, 0);
    applyStimulus("exec040",    0, 0, 1, 1, 8'h00, 9'h040, 1, 0);
    applyStimulus("fetch1AA",   0, 0, 0, 0, 8'h00, 9'h1AA, 0, 0);
    #1 checkOutput("haltCen", {23'b0, c_en}, 32'h001);
    applyStimulus("exec1AA",    0, 0, 0, 0, 8'h00, 9'h1AA, 1, 0);
    for (int i = 0; i < 20; i++)
      applyStimulus($sformatf("halt_%0d", i), 0, 0, 1, 1, 8'hFF, 9'h1AA, 0, 1);

    $display("[TB] reset out of HALT and out of a stall");
    csMem[9'h000] = mkWord(9'h033, 0, 0, 0, 2'd1, 4'b0011, 9'h002, 3'b010, 4'hA, 0, 0);
    applyStimulus("haltRst",    1, 0, 0, 0, 8'h00, 9'h1AA, 0, 1);
    applyStimulus("afterHalt",  0, 0, 0, 0, 8'h00, 9'h000, 0, 0);
    applyStimulus("stall0_a",   0, 1, 0, 0, 8'h00, 9'h000, 1, 0);
    applyStimulus("stall0_b",   0, 1, 0, 0, 8'h00, 9'h000, 1, 0);
    applyStimulus("stallRst",   1, 1, 0, 0, 8'h00, 9'h000, 1, 0);
    applyStimulus("afterStall", 0, 0, 0, 0, 8'h00, 9'h000, 0, 0);
    applyStimulus("exec000b",   0, 0, 0, 0, 8'h00, 9'h000, 1, 0);
    applyStimulus("fetch033",   0, 0, 0, 0, 8'h00, 9'h033, 0, 0);

    checkOutput("sbEmpty", expQ.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
